// File: rtl/barrel_pipe.sv
// rtl/barrel_pipe.sv - pipelined barrel shifter/rotator with valid/ready handshake and global stall
// Define BARREL_PIPE_FLAGS_EN to add the o_zero/o_carry result flags.
module barrel_pipe #(
  parameter int WIDTH = 32,
  parameter int SHW   = $clog2(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_flush,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [WIDTH-1:0] i_data,
  input  logic [SHW-1:0]   i_amt,
  input  logic [2:0]       i_mode,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [WIDTH-1:0] o_data
`ifdef BARREL_PIPE_FLAGS_EN
  ,
  output logic             o_zero,
  output logic             o_carry
`endif
);

  localparam logic [2:0] M_SLL = 3'b001;
  localparam logic [2:0] M_SRL = 3'b010;
  localparam logic [2:0] M_SRA = 3'b011;
  localparam logic [2:0] M_ROL = 3'b100;
  localparam logic [2:0] M_ROR = 3'b101;

  logic             stall;
  logic             vld     [SHW];
  logic [WIDTH-1:0] dat     [SHW];
  logic [SHW-1:0]   amt     [SHW];
  logic [2:0]       mode    [SHW];
  logic             sgn     [SHW];
  logic [WIDTH-1:0] nxt_dat [SHW];
  logic             out_vld;
  logic [WIDTH-1:0] out_dat;

  function automatic logic [WIDTH-1:0] step_data(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       m,
    input logic             s,
    input int               sh
  );
    logic [WIDTH-1:0] r;
    case (m)
      M_SLL:   r = d << sh;
      M_SRL:   r = d >> sh;
      M_SRA:   r = (d >> sh) | (~({WIDTH{1'b1}} >> sh) & {WIDTH{s}});
      M_ROL:   r = (d << sh) | (d >> (WIDTH - sh));
      M_ROR:   r = (d >> sh) | (d << (WIDTH - sh));
      default: r = d;
    endcase
    return r;
  endfunction

  assign stall   = out_vld & ~i_ready;
  assign o_ready = ~stall;
  assign o_valid = out_vld;
  assign o_data  = out_dat;

  // Stage k applies the 2^k step when amount bit k is set.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      nxt_dat[k] = dat[k];
      if (amt[k][k]) nxt_dat[k] = step_data(dat[k], mode[k], sgn[k], 1 << k);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SHW; k++) begin
        vld[k]  <= 1'b0;
        dat[k]  <= '0;
        amt[k]  <= '0;
        mode[k] <= '0;
        sgn[k]  <= 1'b0;
      end
      out_vld <= 1'b0;
      out_dat <= '0;
    end else begin
      if (i_flush) begin
        for (int k = 0; k < SHW; k++) vld[k] <= 1'b0;
        out_vld <= 1'b0;
      end else if (!stall) begin
        vld[0] <= i_valid;
        for (int k = 1; k < SHW; k++) vld[k] <= vld[k-1];
        out_vld <= vld[SHW-1];
      end
      // Data only moves behind a valid op so unknown bubble data never reaches o_data.
      if (!stall) begin
        if (i_valid) begin
          dat[0]  <= i_data;
          amt[0]  <= i_amt;
          mode[0] <= i_mode;
          sgn[0]  <= i_data[WIDTH-1];
        end
        for (int k = 1; k < SHW; k++) begin
          if (vld[k-1]) begin
            dat[k]  <= nxt_dat[k-1];
            amt[k]  <= amt[k-1];
            mode[k] <= mode[k-1];
            sgn[k]  <= sgn[k-1];
          end
        end
        if (vld[SHW-1]) out_dat <= nxt_dat[SHW-1];
      end
    end
  end

`ifdef BARREL_PIPE_FLAGS_EN
  logic cry     [SHW];
  logic nxt_cry [SHW];
  logic out_zero;
  logic out_cry;

  function automatic logic step_carry(
    input logic [WIDTH-1:0] d,
    input logic [2:0]       m,
    input logic             c,
    input int               sh
  );
    logic [WIDTH-1:0] t;
    logic             r;
    r = c;
    case (m)
      M_SLL, M_ROL: begin
        t = d >> (WIDTH - sh);
        r = t[0];
      end
      M_SRL, M_SRA, M_ROR: begin
        t = d >> (sh - 1);
        r = t[0];
      end
      default: r = c;
    endcase
    return r;
  endfunction

  // The last shifting stage leaves the final shifted-out bit; for rotates that bit lands at the result edge.
  always_comb begin
    for (int k = 0; k < SHW; k++) begin
      nxt_cry[k] = cry[k];
      if (amt[k][k]) nxt_cry[k] = step_carry(dat[k], mode[k], cry[k], 1 << k);
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int k = 0; k < SHW; k++) cry[k] <= 1'b0;
      out_zero <= 1'b0;
      out_cry  <= 1'b0;
    end else if (!stall) begin
      if (i_valid) cry[0] <= 1'b0;
      for (int k = 1; k < SHW; k++) begin
        if (vld[k-1]) cry[k] <= nxt_cry[k-1];
      end
      if (vld[SHW-1]) begin
        out_zero <= (nxt_dat[SHW-1] == '0);
        out_cry  <= nxt_cry[SHW-1];
      end
    end
  end

  assign o_zero  = out_zero;
  assign o_carry = out_cry;
`endif

endmodule

// File: tb/tb_barrel_pipe.sv
// tb/tb_barrel_pipe.sv - directed table-driven bench for barrel_pipe (WIDTH=32)
module tb_barrel_pipe;

  localparam int WIDTH = 32;
  localparam int SHW   = 5;
  localparam int NV    = 24;

  localparam logic [2:0] PASS = 3'b000;
  localparam logic [2:0] SLL  = 3'b001;
  localparam logic [2:0] SRL  = 3'b010;
  localparam logic [2:0] SRA  = 3'b011;
  localparam logic [2:0] ROL  = 3'b100;
  localparam logic [2:0] ROR  = 3'b101;
  localparam logic [2:0] P6   = 3'b110;
  localparam logic [2:0] P7   = 3'b111;

  typedef struct {
    logic [2:0]  mode;
    logic [31:0] data;
    logic [4:0]  amt;
    logic [31:0] res;
    logic        zero;
    logic        carry;
  } vec_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             flush;
  logic             in_valid;
  logic             dut_ready;
  logic [WIDTH-1:0] in_data;
  logic [SHW-1:0]   in_amt;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             down_ready;
  logic [WIDTH-1:0] out_data;
`ifdef BARREL_PIPE_FLAGS_EN
  logic             out_zero;
  logic             out_carry;
`endif

  int   checks   = 0;
  int   failures = 0;
  vec_t vecs [NV];

  always #5 clk = ~clk;

  barrel_pipe #(.WIDTH(WIDTH)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .i_flush (flush),
    .i_valid (in_valid),
    .o_ready (dut_ready),
    .i_data  (in_data),
    .i_amt   (in_amt),
    .i_mode  (in_mode),
    .o_valid (out_valid),
    .i_ready (down_ready),
    .o_data  (out_data)
`ifdef BARREL_PIPE_FLAGS_EN
    ,
    .o_zero  (out_zero),
    .o_carry (out_carry)
`endif
  );

  function automatic vec_t mk(input logic [2:0] m, input logic [31:0] d, input logic [4:0] a,
                              input logic [31:0] r, input logic z, input logic c);
    vec_t v;
    v.mode = m; v.data = d; v.amt = a; v.res = r; v.zero = z; v.carry = c;
    return v;
  endfunction

  task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic drive_op(input logic [2:0] m, input logic [31:0] d, input logic [4:0] a);
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    in_amt   = a;
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_mode  = 3'b000;
    in_data  = '0;
    in_amt   = '0;
  endtask

  // Caller is at a negedge with an empty pipeline; checks latency, result and single-cycle valid.
  task automatic run_single(input logic [2:0] m, input logic [31:0] d, input logic [4:0] a,
                            input logic [31:0] exp, input string name);
    int   t;
    logic found;
    drive_op(m, d, a);
    @(negedge clk);
    idle();
    t = 1;
    found = 1'b0;
    while (!found && t < 20) begin
      if (out_valid) found = 1'b1;
      else begin
        @(negedge clk);
        t++;
      end
    end
    check_int({name, "_latency"}, found ? t - 1 : -1, 5);
    check32({name, "_data"}, out_data, exp);
    @(negedge clk);
    check32({name, "_valid_one_cycle"}, {31'd0, out_valid}, 32'd0);
  endtask

  initial begin
    vecs[0]  = mk(SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    vecs[1]  = mk(SRL, 32'h8000_0000, 5'd4,  32'h0800_0000, 1'b0, 1'b0);
    vecs[2]  = mk(SRA, 32'h8000_0000, 5'd4,  32'hF800_0000, 1'b0, 1'b0);
    vecs[3]  = mk(ROL, 32'h8000_0001, 5'd1,  32'h0000_0003, 1'b0, 1'b1);
    vecs[4]  = mk(ROR, 32'h0000_0003, 5'd1,  32'h8000_0001, 1'b0, 1'b1);
    vecs[5]  = mk(P7,  32'h1234_5678, 5'd5,  32'h1234_5678, 1'b0, 1'b0);
    vecs[6]  = mk(SLL, 32'hDEAD_BEEF, 5'd0,  32'hDEAD_BEEF, 1'b0, 1'b0);
    vecs[7]  = mk(SRA, 32'h8000_0000, 5'd31, 32'hFFFF_FFFF, 1'b0, 1'b0);
    vecs[8]  = mk(SRA, 32'h7FFF_FFFF, 5'd31, 32'h0000_0000, 1'b1, 1'b1);
    vecs[9]  = mk(SRL, 32'hFFFF_FFFF, 5'd31, 32'h0000_0001, 1'b0, 1'b1);
    vecs[10] = mk(ROL, 32'h0000_0001, 5'd31, 32'h8000_0000, 1'b0, 1'b0);
    vecs[11] = mk(ROR, 32'h0000_0001, 5'd31, 32'h0000_0002, 1'b0, 1'b0);
    vecs[12] = mk(P6,  32'hCAFE_F00D, 5'd7,  32'hCAFE_F00D, 1'b0, 1'b0);
    vecs[13] = mk(SRA, 32'h8000_0001, 5'd0,  32'h8000_0001, 1'b0, 1'b0);
    vecs[14] = mk(SLL, 32'h0000_0003, 5'd31, 32'h8000_0000, 1'b0, 1'b1);
    vecs[15] = mk(SRL, 32'h0000_0001, 5'd1,  32'h0000_0000, 1'b1, 1'b1);
    vecs[16] = mk(SLL, 32'h4000_0000, 5'd2,  32'h0000_0000, 1'b1, 1'b1);
    vecs[17] = mk(ROR, 32'h0000_0001, 5'd1,  32'h8000_0000, 1'b0, 1'b1);
    vecs[18] = mk(ROL, 32'h1234_5678, 5'd8,  32'h3456_7812, 1'b0, 1'b0);
    vecs[19] = mk(ROR, 32'h1234_5678, 5'd4,  32'h8123_4567, 1'b0, 1'b1);
    vecs[20] = mk(SRL, 32'h1234_5678, 5'd12, 32'h0001_2345, 1'b0, 1'b0);
    vecs[21] = mk(SLL, 32'h1234_5678, 5'd20, 32'h6780_0000, 1'b0, 1'b1);
    vecs[22] = mk(SRA, 32'h8765_4321, 5'd8,  32'hFF87_6543, 1'b0, 1'b0);
    vecs[23] = mk(PASS, 32'h0000_0000, 5'd3, 32'h0000_0000, 1'b1, 1'b0);

    rst_n = 1'b0;
    flush = 1'b0;
    down_ready = 1'b1;
    idle();
    #12;
    check32("reset_valid", {31'd0, out_valid}, 32'd0);
    check32("reset_data", out_data, 32'd0);
    check32("reset_ready", {31'd0, dut_ready}, 32'd1);
`ifdef BARREL_PIPE_FLAGS_EN
    check32("reset_flags", {30'd0, out_zero, out_carry}, 32'd0);
`endif

    @(negedge clk);
    rst_n = 1'b1;
    run_single(SLL, 32'h0000_0001, 5'd31, 32'h8000_0000, "first_sll");

    // Back-to-back stream: vector c-6 must be on the output at negedge c.
    for (int c = 0; c < NV + 7; c++) begin
      @(negedge clk);
      if (c >= 6 && c - 6 < NV) begin
        check32($sformatf("vec%0d_valid", c - 6), {31'd0, out_valid}, 32'd1);
        check32($sformatf("vec%0d_data", c - 6), out_data, vecs[c-6].res);
`ifdef BARREL_PIPE_FLAGS_EN
        check32($sformatf("vec%0d_zero", c - 6), {31'd0, out_zero}, {31'd0, vecs[c-6].zero});
        check32($sformatf("vec%0d_carry", c - 6), {31'd0, out_carry}, {31'd0, vecs[c-6].carry});
`endif
      end else begin
        check32($sformatf("stream_idle%0d_valid", c), {31'd0, out_valid}, 32'd0);
      end
      if (c < NV) drive_op(vecs[c].mode, vecs[c].data, vecs[c].amt);
      else idle();
    end

    // Stall: hold the first result for 4 cycles, then drain the rest.
    begin
      logic [31:0] sexp [3];
      int          got;
      int          t;
      sexp[0] = 32'h0000_0003;
      sexp[1] = 32'h0000_000F;
      sexp[2] = 32'hC000_0000;
      drive_op(ROL, 32'h8000_0001, 5'd1);
      @(negedge clk);
      drive_op(SRL, 32'h0000_00F0, 5'd4);
      @(negedge clk);
      drive_op(SRA, 32'h8000_0000, 5'd1);
      @(negedge clk);
      idle();
      t = 0;
      while (!out_valid && t < 20) begin
        @(negedge clk);
        t++;
      end
      check32("stall_first_valid", {31'd0, out_valid}, 32'd1);
      down_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        check32($sformatf("stall%0d_ready", i), {31'd0, dut_ready}, 32'd0);
        check32($sformatf("stall%0d_valid", i), {31'd0, out_valid}, 32'd1);
        check32($sformatf("stall%0d_data", i), out_data, sexp[0]);
      end
      down_ready = 1'b1;
      got = 0;
      for (int i = 0; i < 10; i++) begin
        if (out_valid) begin
          if (got < 3) check32($sformatf("drain%0d_data", got), out_data, sexp[got]);
          got++;
        end
        @(negedge clk);
      end
      check_int("drain_count", got, 3);
    end

    // Flush with three ops in flight and a new op offered in the flush cycle.
    drive_op(SLL, 32'h0000_0001, 5'd1);
    @(negedge clk);
    drive_op(SLL, 32'h0000_0001, 5'd2);
    @(negedge clk);
    drive_op(SLL, 32'h0000_0001, 5'd3);
    @(negedge clk);
    drive_op(SLL, 32'h0000_0001, 5'd5);
    flush = 1'b1;
    check32("flush_ready", {31'd0, dut_ready}, 32'd1);
    @(negedge clk);
    flush = 1'b0;
    idle();
    for (int i = 0; i < 5; i++) begin
      check32($sformatf("flush%0d_valid", i), {31'd0, out_valid}, 32'd0);
      @(negedge clk);
    end
    run_single(SLL, 32'h0000_0001, 5'd4, 32'h0000_0010, "post_flush");

    // Asynchronous reset while results are streaming out.
    for (int i = 0; i < 6; i++) begin
      drive_op(vecs[i].mode, vecs[i].data, vecs[i].amt);
      @(negedge clk);
    end
    idle();
    check32("pre_reset_valid", {31'd0, out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check32("async_reset_valid", {31'd0, out_valid}, 32'd0);
    check32("async_reset_data", out_data, 32'd0);
    check32("async_reset_ready", {31'd0, dut_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_single(SRA, 32'hFFFF_FFFE, 5'd1, 32'hFFFF_FFFF, "post_reset_sra");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check32($sformatf("post_reset_quiet%0d", i), {31'd0, out_valid}, 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
